// File: rtl/stage_memory_if.sv
// Bundle between the EX/MEM pipe, the memory stage and its single-port data memory.
// Optional MEM_STRIDE_EN adds the stride field.
interface stage_memory_if #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int addrWidth    = 16
);
    logic                                    start;
    logic                                    memWrite;
    logic                                    memRead;
    logic                                    isVector;
    logic [addrWidth-1:0]                    baseAddr;
    logic [vectorSize-1:0][registerSize-1:0] storeData;
`ifdef MEM_STRIDE_EN
    logic [addrWidth-1:0]                    stride;
`endif
    logic [addrWidth-1:0]                    mem_addr;
    logic                                    mem_we;
    logic                                    mem_re;
    logic [registerSize-1:0]                 mem_wdata;
    logic [registerSize-1:0]                 mem_rdata;
    logic [vectorSize-1:0][registerSize-1:0] loadData;
    logic                                    done;
    logic                                    stall;

    modport master (
`ifdef MEM_STRIDE_EN
        output stride,
`endif
        output start, memWrite, memRead, isVector, baseAddr, storeData, mem_rdata,
        input  mem_addr, mem_we, mem_re, mem_wdata, loadData, done, stall
    );

    modport slave (
`ifdef MEM_STRIDE_EN
        input  stride,
`endif
        input  start, memWrite, memRead, isVector, baseAddr, storeData, mem_rdata,
        output mem_addr, mem_we, mem_re, mem_wdata, loadData, done, stall
    );
endinterface

// File: rtl/stage_memory.sv
// Memory stage: serializes scalar/vector loads and stores one lane per cycle onto a
// single-port data memory. Define MEM_STRIDE_EN for a per-op lane address stride.
module stage_memory #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int addrWidth    = 16
) (
    input  logic             clk,
    input  logic             rst,
    stage_memory_if.slave    bus
);
    localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} stateT;

    stateT                                   state;
    stateT                                   nextState;
    logic                                    opStore;
    logic                                    vecReg;
    logic [addrWidth-1:0]                    baseReg;
    logic [vectorSize-1:0][registerSize-1:0] storeReg;
    logic [vectorSize-1:0][registerSize-1:0] loadReg;
    logic [LW-1:0]                           laneCnt;
    logic [LW-1:0]                           lastLane;
    logic [LW-1:0]                           prevLane;
    logic                                    prevRead;
    logic [addrWidth-1:0]                    laneExt;
    logic [addrWidth-1:0]                    laneOff;

    logic accept;
    assign accept = (state == IDLE) && bus.start;

    assign lastLane = vecReg ? LW'(vectorSize - 1) : '0;
    assign laneExt  = {{(addrWidth-LW){1'b0}}, laneCnt};

`ifdef MEM_STRIDE_EN
    logic [addrWidth-1:0] strideReg;
    assign laneOff = laneExt * strideReg;
`else
    assign laneOff = laneExt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState     = state;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;
        bus.stall     = 1'b0;
        case (state)
            IDLE: begin
                bus.stall = bus.start;
                if (bus.start)
                    nextState = (bus.memWrite || bus.memRead) ? ACCESS : DONE;
            end
            ACCESS: begin
                bus.stall    = 1'b1;
                bus.mem_addr = baseReg + laneOff;
                if (opStore) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = storeReg[laneCnt];
                end else begin
                    bus.mem_re = 1'b1;
                end
                if (laneCnt == lastLane)
                    nextState = opStore ? DONE : DRAIN;
            end
            DRAIN: begin
                bus.stall = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Read data for a lane returns one cycle after its access; prevLane remembers where it goes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            opStore  <= 1'b0;
            vecReg   <= 1'b0;
            baseReg  <= '0;
            storeReg <= '0;
            loadReg  <= '0;
            laneCnt  <= '0;
            prevLane <= '0;
            prevRead <= 1'b0;
`ifdef MEM_STRIDE_EN
            strideReg <= '0;
`endif
        end else begin
            prevRead <= (state == ACCESS) && !opStore;
            prevLane <= laneCnt;
            if (prevRead)
                loadReg[prevLane] <= bus.mem_rdata;
            if (accept) begin
                opStore  <= bus.memWrite;
                vecReg   <= bus.isVector;
                baseReg  <= bus.baseAddr;
                storeReg <= bus.storeData;
                laneCnt  <= '0;
`ifdef MEM_STRIDE_EN
                strideReg <= bus.stride;
`endif
            end else if (state == ACCESS) begin
                laneCnt <= laneCnt + LW'(1);
            end
        end
    end

    assign bus.loadData = loadReg;
endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed plan cases plus randomized ops
// checked cycle by cycle against an access-list/memory-array reference model.
module tb_stage_memory;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] tbMem  [0:65535];
    logic [7:0] refMem [0:65535];
    logic [7:0] refLoad [4];

    stage_memory_if #(.registerSize(8), .vectorSize(4), .addrWidth(16)) bus ();

    stage_memory #(.registerSize(8), .vectorSize(4), .addrWidth(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory responder: write on we, registered read data on re.
    always @(posedge clk) begin
        if (bus.mem_we) tbMem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= tbMem[bus.mem_addr];
    end

    function automatic logic [15:0] effStride(input logic [15:0] s);
`ifdef MEM_STRIDE_EN
        return s;
`else
        return (s == 16'hFFFF) ? 16'd1 : 16'd1;
`endif
    endfunction

    function automatic logic [31:0] refVec();
        return {refLoad[3], refLoad[2], refLoad[1], refLoad[0]};
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        tbMem[a]  = v;
        refMem[a] = v;
    endtask

    task automatic scramble();
        bus.start     = 1'($urandom);
        bus.memWrite  = 1'($urandom);
        bus.memRead   = 1'($urandom);
        bus.isVector  = 1'($urandom);
        bus.baseAddr  = 16'($urandom);
        bus.storeData = $urandom;
`ifdef MEM_STRIDE_EN
        bus.stride    = 16'($urandom);
`endif
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (cycles) @(negedge clk);
        for (int k = 0; k < 4; k++) refLoad[k] = 8'h00;
    endtask

    // Runs one operation and checks every cycle from accept through the done pulse.
    task automatic runOp(input bit wr, input bit rd, input bit vec, input logic [15:0] base,
                         input logic [15:0] strd, input logic [31:0] sdata, input string tag);
        int         lanes;
        bit         isStore;
        bit         isLoad;
        logic [15:0] a;
        logic [17:0] gotAcc;
        logic [17:0] expAcc;
        isStore = wr;
        isLoad  = !wr && rd;
        lanes   = (wr || rd) ? (vec ? 4 : 1) : 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.memWrite  = wr;
        bus.memRead   = rd;
        bus.isVector  = vec;
        bus.baseAddr  = base;
        bus.storeData = sdata;
`ifdef MEM_STRIDE_EN
        bus.stride    = strd;
`endif
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_stall: got %b want 1", tag, bus.stall);
        end
        @(negedge clk);
        for (int i = 0; i < lanes; i++) begin
            a = base + 16'(i) * effStride(strd);
            gotAcc = {bus.mem_we, bus.mem_re, bus.mem_addr};
            expAcc = {isStore, isLoad, a};
            total++;
            if (gotAcc !== expAcc) begin
                bad++;
                $display("FAIL %s access lane%0d {we,re,addr}: got %h want %h", tag, i, gotAcc, expAcc);
            end
            if (isStore) begin
                total++;
                if (bus.mem_wdata !== sdata[8*i +: 8]) begin
                    bad++;
                    $display("FAIL %s wdata lane%0d: got %h want %h", tag, i, bus.mem_wdata, sdata[8*i +: 8]);
                end
                refMem[a] = sdata[8*i +: 8];
            end else begin
                refLoad[i] = refMem[a];
            end
            total++;
            if ({bus.stall, bus.done} !== 2'b10) begin
                bad++;
                $display("FAIL %s busy lane%0d {stall,done}: got %b want 10", tag, i, {bus.stall, bus.done});
            end
            scramble();
            @(negedge clk);
        end
        if (isLoad) begin
            total++;
            if ({bus.stall, bus.done, bus.mem_we, bus.mem_re} !== 4'b1000) begin
                bad++;
                $display("FAIL %s drain {stall,done,we,re}: got %b want 1000", tag,
                         {bus.stall, bus.done, bus.mem_we, bus.mem_re});
            end
            scramble();
            @(negedge clk);
        end
        total++;
        if ({bus.done, bus.stall, bus.mem_we, bus.mem_re} !== 4'b1000) begin
            bad++;
            $display("FAIL %s done {done,stall,we,re}: got %b want 1000", tag,
                     {bus.done, bus.stall, bus.mem_we, bus.mem_re});
        end
        total++;
        if (bus.loadData !== refVec()) begin
            bad++;
            $display("FAIL %s loadData: got %h want %h", tag, bus.loadData, refVec());
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        applyReset(3);
        total++;
        if (bus.mem_addr !== 16'h0) begin bad++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
        total++;
        if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we: got %b want 0", bus.mem_we); end
        total++;
        if (bus.mem_re !== 1'b0) begin bad++; $display("FAIL reset mem_re: got %b want 0", bus.mem_re); end
        total++;
        if (bus.mem_wdata !== 8'h0) begin bad++; $display("FAIL reset mem_wdata: got %h want 0", bus.mem_wdata); end
        total++;
        if (bus.loadData !== 32'h0) begin bad++; $display("FAIL reset loadData: got %h want 0", bus.loadData); end
        total++;
        if ({bus.done, bus.stall} !== 2'b00) begin bad++; $display("FAIL reset {done,stall}: got %b want 00", {bus.done, bus.stall}); end
        rst = 1'b1;
    endtask

    task automatic test_vector_store();
        runOp(1'b1, 1'b0, 1'b1, 16'h0010, 16'd1, 32'h44332211, "vec_store");
    endtask

    task automatic test_vector_load();
        for (int k = 0; k < 4; k++) poke(16'h0020 + 16'(k), 8'hA0 + 8'(k));
        runOp(1'b0, 1'b1, 1'b1, 16'h0020, 16'd1, 32'h0, "vec_load");
        total++;
        if (bus.loadData !== 32'hA3A2A1A0) begin
            bad++;
            $display("FAIL vec_load literal: got %h want a3a2a1a0", bus.loadData);
        end
    endtask

    task automatic test_scalar_load();
        poke(16'h0005, 8'h7E);
        runOp(1'b0, 1'b1, 1'b0, 16'h0005, 16'd1, 32'h0, "scalar_load");
        total++;
        if (bus.loadData !== 32'hA3A2A17E) begin
            bad++;
            $display("FAIL scalar_load literal: got %h want a3a2a17e", bus.loadData);
        end
    endtask

    task automatic test_wrap_store();
        runOp(1'b1, 1'b0, 1'b1, 16'hFFFE, 16'd1, 32'hD4C3B2A1, "wrap_store");
        runOp(1'b0, 1'b1, 1'b1, 16'hFFFE, 16'd1, 32'h0, "wrap_load");
    endtask

    task automatic test_noop_and_both();
        runOp(1'b0, 1'b0, 1'b1, 16'h0040, 16'd1, 32'h12345678, "noop");
        runOp(1'b1, 1'b1, 1'b1, 16'h0030, 16'd1, 32'h9988CCBB, "both_is_store");
        runOp(1'b0, 1'b1, 1'b1, 16'h0030, 16'd1, 32'h0, "both_readback");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.start = 1'b1; bus.memWrite = 1'b1; bus.memRead = 1'b0; bus.isVector = 1'b1;
        bus.baseAddr = 16'h0050; bus.storeData = 32'h5A6B7C8D;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b1, 16'h0051}) begin
            bad++;
            $display("FAIL abort second_access {we,addr}: got %h want 10051", {bus.mem_we, bus.mem_addr});
        end
        refMem[16'h0050] = 8'h8D;
        refMem[16'h0051] = 8'h7C;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) refLoad[k] = 8'h00;
        total++;
        if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.done, bus.stall} !== 28'h0) begin
            bad++;
            $display("FAIL abort outputs: got %h want 0",
                     {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.done, bus.stall});
        end
        total++;
        if (bus.loadData !== 32'h0) begin bad++; $display("FAIL abort loadData: got %h want 0", bus.loadData); end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({bus.done, bus.mem_we, bus.stall} !== 3'b000) begin
                bad++;
                $display("FAIL abort quiet {done,we,stall}: got %b want 000", {bus.done, bus.mem_we, bus.stall});
            end
        end
        runOp(1'b0, 1'b1, 1'b1, 16'h0050, 16'd1, 32'h0, "abort_readback");
    endtask

    task automatic test_random();
        logic [15:0] base;
        for (int n = 0; n < 30; n++) begin
            base = ($urandom_range(0, 7) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                               : 16'($urandom_range(0, 63));
            runOp(1'($urandom), 1'($urandom), 1'($urandom), base, 16'($urandom_range(0, 5)),
                  $urandom, "random");
        end
    endtask

`ifdef MEM_STRIDE_EN
    task automatic test_stride();
        for (int k = 0; k < 4; k++) poke(16'h0100 + 16'(4 * k), 8'hC0 + 8'(k));
        runOp(1'b0, 1'b1, 1'b1, 16'h0100, 16'd4, 32'h0, "stride4_load");
        total++;
        if (bus.loadData !== 32'hC3C2C1C0) begin
            bad++;
            $display("FAIL stride4 literal: got %h want c3c2c1c0", bus.loadData);
        end
        runOp(1'b1, 1'b0, 1'b1, 16'h0200, 16'd0, 32'h11223344, "stride0_store");
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.start = 1'b0; bus.memWrite = 1'b0; bus.memRead = 1'b0; bus.isVector = 1'b0;
        bus.baseAddr = '0; bus.storeData = '0; bus.mem_rdata = '0;
`ifdef MEM_STRIDE_EN
        bus.stride = '0;
`endif
        for (int k = 0; k < 65536; k++) begin
            tbMem[k]  = 8'(k) ^ 8'h5A;
            refMem[k] = 8'(k) ^ 8'h5A;
        end
        for (int k = 0; k < 4; k++) refLoad[k] = 8'h00;

        test_reset();
        test_vector_store();
        test_vector_load();
        test_scalar_load();
        test_wrap_store();
        test_noop_and_both();
        test_reset_abort();
`ifdef MEM_STRIDE_EN
        test_stride();
`endif
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
